alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 153 +++++++++++++++
 tb/tb_alu_result_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
//==============================================================================
// Module      : alu_result_stage
// Description : Single-cycle 16-bit ALU feeding a two-entry result FIFO.
//               A valid/ready handshake governs both sides. The output
//               presents the FIFO head (result plus Z/C/V flags) and counts
//               consumed results in op_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic [15:0]      op_count
);

  // Each entry is packed as {result, Z, C, V}.
  localparam int                c_EW        = WIDTH + 3;
  localparam int                c_PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0]   c_PTR_ONE   = c_PW'(1);
  localparam logic [c_PW:0]     c_CNT_ONE   = (c_PW + 1)'(1);
  localparam logic [c_PW:0]     c_DEPTH_CNT = (c_PW + 1)'(DEPTH);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_NOR  = 3'b101;
  localparam logic [2:0] c_OP_SLT  = 3'b110;
  localparam logic [2:0] c_OP_SLTU = 3'b111;

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_z;
  logic [c_EW-1:0]  w_entry;
  logic [c_EW-1:0]  w_head;
  logic             w_push;
  logic             w_pop;

  logic [c_EW-1:0]  r_mem [DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_PW:0]    r_count;
  logic [15:0]      r_op_count;

  // Shared adder serves ADD and SUB; SUB is A + ~B + 1.
  always_comb begin
    w_cin   = (op == c_OP_SUB);
    w_b_eff = w_cin ? ~B : B;
    w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
  end

  // Result and flag selection for the operand set being presented.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      c_OP_AND:  w_res = A & B;
      c_OP_OR:   w_res = A | B;
      c_OP_XOR:  w_res = A ^ B;
      c_OP_NOR:  w_res = ~(A | B);
      c_OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default:   w_res = '0;
    endcase
    w_z = (w_res == '0);
  end

  assign w_entry   = {w_res, w_z, w_c, w_v};
  assign in_ready  = (r_count < c_DEPTH_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rptr];
  assign op_count  = r_op_count;

  // Entry storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - c_CNT_ONE;
    end
  end

  // Consumed-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  // Head presentation, forced to zero when the queue is empty.
  always_comb begin
    Res = '0;
    Z   = 1'b0;
    C   = 1'b0;
    V   = 1'b0;
    if (out_valid) begin
      Res = w_head[c_EW-1:3];
      Z   = w_head[2];
      C   = w_head[1];
      V   = w_head[0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
//==============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage: vector table,
//               expected-result queue, and handshake corner sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_result_stage;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Res;
  logic        Z;
  logic        C;
  logic        V;
  logic [15:0] op_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b1;
  exp_t sb[$];

  vec_t tbl [13];
  vec_t bp_and, bp_xor, bp_slt, pp_sub, pp_sltu;

  alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Res       (Res),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .op_count  (op_count)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] r, input logic z, input logic c, input logic v);
    vec_t t;
    t.op = o; t.a = a; t.b = b; t.res = r; t.z = z; t.c = c; t.v = v;
    return t;
  endfunction

  // Present one operand set for one cycle; expectation is queued only if accepted.
  task automatic send(input vec_t t, output logic acc);
    exp_t e;
    in_valid = 1'b1;
    op = t.op; A = t.a; B = t.b;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      e.res = t.res; e.z = t.z; e.c = t.c; e.v = t.v;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reset pulse placed between edges; leaves caller just after a rising edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Output monitor: a pop is about to happen whenever valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_en) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            chk("spurious_output", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("res", {16'd0, Res}, {16'd0, e.res});
            chk("flags_zcv", {29'd0, Z, C, V}, {29'd0, e.z, e.c, e.v});
          end
        end
      end else begin
        chk("idle_outputs_zero", {13'd0, Res, Z, C, V}, 32'd0);
      end
    end
  end

  initial begin
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; A = '0; B = '0; out_ready = 1'b1;

    tbl[0]  = mk(3'b001, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0); // OR
    tbl[1]  = mk(3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1); // ADD ovf
    tbl[2]  = mk(3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0); // ADD carry
    tbl[3]  = mk(3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0); // AND
    tbl[4]  = mk(3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0); // XOR zero
    tbl[5]  = mk(3'b101, 16'h0F0F, 16'hF000, 16'h00F0, 1'b0, 1'b0, 1'b0); // NOR
    tbl[6]  = mk(3'b011, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0); // SUB borrow
    tbl[7]  = mk(3'b011, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1); // SUB ovf
    tbl[8]  = mk(3'b011, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b1, 1'b0); // SUB zero
    tbl[9]  = mk(3'b110, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0); // SLT -1<1
    tbl[10] = mk(3'b111, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0); // SLTU
    tbl[11] = mk(3'b110, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0); // SLT 1<-1
    tbl[12] = mk(3'b111, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0); // SLTU

    bp_and  = mk(3'b000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    bp_xor  = mk(3'b100, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0, 1'b0);
    bp_slt  = mk(3'b110, 16'h8000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    pp_sub  = mk(3'b011, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    pp_sltu = mk(3'b111, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_outputs", {13'd0, Res, Z, C, V}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors, back to back with the consumer always ready
    for (int i = 0; i < 13; i++) begin
      send(tbl[i], acc);
      chk("table_accept", {31'd0, acc}, 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("table_drained", sb.size(), 32'd0);
    chk("table_op_count", {16'd0, op_count}, 32'd13);

    // Backpressure: third set must be refused, order preserved
    do_reset();
    out_ready = 1'b0;
    send(bp_and, acc);
    chk("bp_accept1", {31'd0, acc}, 32'd1);
    send(bp_xor, acc);
    chk("bp_accept2", {31'd0, acc}, 32'd1);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    send(bp_slt, acc);
    chk("bp_third_refused", {31'd0, acc}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_head_stable", {16'd0, Res}, 32'h00F0);
    chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 32'd0);
    chk("bp_op_count", {16'd0, op_count}, 32'd2);

    // Simultaneous push and pop at occupancy 1
    do_reset();
    out_ready = 1'b0;
    send(pp_sub, acc);
    chk("pp_accept_sub", {31'd0, acc}, 32'd1);
    out_ready = 1'b1;
    send(pp_sltu, acc);
    chk("pp_accept_sltu", {31'd0, acc}, 32'd1);
    chk("pp_count1_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_count1_ready", {31'd0, in_ready}, 32'd1);
    chk("pp_new_head", {16'd0, Res}, 32'h0001);
    repeat (2) @(posedge clk);
    #1;
    chk("pp_drained", sb.size(), 32'd0);
    chk("pp_op_count", {16'd0, op_count}, 32'd2);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    send(bp_and, acc);
    send(bp_xor, acc);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_op_count", {16'd0, op_count}, 32'd0);
    chk("async_rst_outputs", {13'd0, Res, Z, C, V}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(tbl[0], acc);
    chk("post_rst_first_accept", {31'd0, acc}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_op_count", {16'd0, op_count}, 32'd1);

    // op_count wrap: stream one result per cycle until 65536 pops total
    mon_en = 1'b0;
    op = 3'b000; A = 16'h0000; B = 16'h0000;
    in_valid = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("op_count_wrap", {16'd0, op_count}, 32'd0);
    @(posedge clk);
    #1;
    chk("op_count_after_wrap", {16'd0, op_count}, 32'd1);
    chk("stream_drained_valid", {31'd0, out_valid}, 32'd0);
    mon_en = 1'b1;

    chk("final_scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
